game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Top-level sequencer for the two-snake game. It replaces the gated game clock with single-cycle step enables.
- It owns the game state machine (idle/run/pause/over), the speed setting, the per-snake direction commit with reversal rejection, and the clear/pause key handling.
- It sits between the raw keystroke bus and the snake-movement/collision datapath. All logic runs on the 50 MHz system clock.

Parameters:
- TICK_BASE, 12500000, cycles per game tick at the fastest rate (4 Hz at 50 MHz); set small in simulation.
- CNT_W, 28, width of the tick counter; must hold TICK_BASE*8-1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- keystroke  in  12  key levels; same bit map as the core:
  - [3:0] snake1 L/R/U/D, [7:4] snake2 L/R/U/D
  - [8] clear, [9] pause, [10] faster, [11] slower
- dead1  in  1  level: snake1 has collided (from collision checker).
- dead2  in  1  level: snake2 has collided.
- step1  out  1  one-cycle pulse: advance snake1 by one cell.
- step2  out  1  one-cycle pulse: advance snake2 by one cell.
- dir1  out  2  committed direction of snake1: 00 left, 01 right, 10 up, 11 down.
- dir2  out  2  committed direction of snake2, same encoding.
- clk_rate  out  2  speed code: 0=4 Hz, 1=2 Hz, 2=1 Hz, 3=0.5 Hz.
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
- game_clear  out  1  one-cycle pulse: datapath must reload initial snakes, scores and food.

Behaviour:
- Reset values: state=IDLE, clk_rate=2, dir1=01, dir2=00, pending dirs equal committed, step1=step2=0, game_clear=0, tick counter=0, key history=0.
- Key edges: keys [8..11] registered each cycle; an action fires on the 0->1 edge only. A held key acts once.
- Direction keys are levels. Within one group, the lowest set bit wins (L>R>U>D). No bit set means no request.
- Speed control:
  - Edge on [10]: clk_rate-1, saturating at 0.
  - Edge on [11]: clk_rate+1, saturating at 3.
  - Both edges in the same cycle: no change.
  - Any clk_rate change zeroes the tick counter.
- Tick period P = TICK_BASE << clk_rate cycles.
  - Counter counts only in RUN, holds in PAUSE and OVER, and is zeroed in IDLE.
  - Tick fires in the cycle the counter equals P-1, then the counter wraps to 0.
- Step pulses, on a tick in RUN:
  - step1 = !dead1, step2 = !dead2.
  - Outputs are registered, so the pulse appears 1 cycle after the tick cycle.
  - Never asserted outside RUN.
- Direction commit:
  - Pending direction takes a requested dir unless it reverses the committed dir. Reversal: same bit[1], different bit[0].
  - On the step pulse cycle, committed dir <= pending.
  - Committed dir changes only with a step, so at most one turn per tick and no 180-degree turn is possible.
- FSM transitions, evaluated in order; first match wins:
  - Any state, edge [8]: -> IDLE, game_clear=1 for one cycle, dirs and pending return to reset values, clk_rate retained.
  - IDLE: any direction request from either snake -> RUN. That request loads pending (subject to reversal rule) the same cycle.
  - RUN: dead1 && dead2 -> OVER. Otherwise edge [9] -> PAUSE.
  - PAUSE: edge [9] -> RUN; the counter resumes from its held value.
  - OVER: only clear leaves it.
- A single dead snake simply stops receiving steps; the game continues for the other.
- Simultaneous clear and pause edges: clear wins.
- A tick in the same cycle as a pause edge still issues its step.
- rst mid-game behaves exactly as the reset values above; no game_clear pulse is issued.

Decomposition:
- Shared package snake_pkg:
  - direction enum: DIR_L=0, DIR_R=1, DIR_U=2, DIR_D=3
  - state enum: ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER
  - key bit index constants: K_CLR=8, K_PAUSE=9, K_FAST=10, K_SLOW=11
  - reset direction constants
- One sub-module: dir_latch, instantiated twice. It contains the key-to-direction priority encode, the reversal reject, the pending register and the commit on step.

Test Plan (TICK_BASE=4, so P=16 cycles at clk_rate 2):
1. Reset, then press key[1] for 1 cycle -> state=RUN; step1/step2 pulse every 16 cycles; dir1 stays 01.
2. In RUN with dir1=01, hold key[0] (left) -> pending unchanged; dir1 stays 01 after next step. Then press key[2] -> dir1=10 on the next step1 pulse, not before.
3. Edge key[10] twice from clk_rate=2, then a third time -> clk_rate 1, 0, 0 (saturates); steps every 4 cycles. Edges [10] and [11] in the same cycle -> no change.
4. Edge key[9] at counter=10 -> PAUSE; no steps for 100 cycles. Edge key[9] again -> RUN; first step arrives 6 cycles later (counter resumes from 10).
5. dead1=1 in RUN -> only step2 pulses. Then dead2=1 -> state=OVER; no steps. Edge key[8] -> game_clear pulse 1 cycle; state=IDLE; dir1=01, dir2=00.
6. Same-cycle edges on key[8] and key[9] while in RUN -> IDLE plus game_clear; no PAUSE entered.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake game sequencer
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int K_CLR   = 8;
  localparam int K_PAUSE = 9;
  localparam int K_FAST  = 10;
  localparam int K_SLOW  = 11;

  localparam dir_t DIR1_RST = DIR_R;
  localparam dir_t DIR2_RST = DIR_L;

  // Opposite directions share the axis bit and differ in the sense bit.
  function automatic logic is_reversal(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/game_ctrl_dir_latch.sv
// rtl/game_ctrl_dir_latch.sv - per-snake direction request, reversal reject and commit
module dir_latch
  import snake_pkg::*;
#(
  parameter dir_t RST_DIR = DIR_R
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [3:0] keys,
  input  logic       commit,
  output dir_t       dir
);

  logic req_vld;
  dir_t req_dir;
  dir_t pending;
  dir_t eff_dir;

  // Lowest set key wins; the reversal test uses the direction in force after this cycle,
  // so a request arriving on a commit cycle cannot queue a 180-degree turn.
  always_comb begin
    req_vld = |keys;
    req_dir = DIR_L;
    if (keys[0])      req_dir = DIR_L;
    else if (keys[1]) req_dir = DIR_R;
    else if (keys[2]) req_dir = DIR_U;
    else if (keys[3]) req_dir = DIR_D;
    eff_dir = commit ? pending : dir;
  end

  // Pending direction follows accepted requests; committed direction follows pending on a step.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pending <= RST_DIR;
      dir     <= RST_DIR;
    end else begin
      if (commit) dir <= pending;
      if (req_vld && !is_reversal(req_dir, eff_dir)) pending <= req_dir;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencer: state machine, speed, tick and step enables
module game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_BASE = 12500000,
  parameter int CNT_W     = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keystroke,
  input  logic        dead1,
  input  logic        dead2,
  output logic        step1,
  output logic        step2,
  output logic [1:0]  dir1,
  output logic [1:0]  dir2,
  output logic [1:0]  clk_rate,
  output logic [1:0]  state,
  output logic        game_clear
);

  state_t           state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
  logic [11:8]      key_q, key_edge;
  logic             clr_e, pause_e, fast_e, slow_e;
  logic             req_any, tick, step1_d, step2_d;
  dir_t             dir1_q, dir2_q;

  assign key_edge = keystroke[11:8] & ~key_q;
  assign clr_e    = key_edge[K_CLR];
  assign pause_e  = key_edge[K_PAUSE];
  assign fast_e   = key_edge[K_FAST];
  assign slow_e   = key_edge[K_SLOW];
  assign req_any  = (|keystroke[3:0]) || (|keystroke[7:4]);

  // Tick period doubles per speed step; a tick is only meaningful while running.
  always_comb begin
    period_m1 = (CNT_W'(TICK_BASE) << rate_q) - CNT_W'(1);
    tick      = (state_q == ST_RUN) && (cnt_q == period_m1);
    step1_d   = tick && !dead1 && !clr_e;
    step2_d   = tick && !dead2 && !clr_e;
  end

  // Next game state; clear takes precedence over every other transition.
  always_comb begin
    state_d = state_q;
    if (clr_e) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (req_any) state_d = ST_RUN;
        ST_RUN: begin
          if (dead1 && dead2) state_d = ST_OVER;
          else if (pause_e)   state_d = ST_PAUSE;
        end
        ST_PAUSE: if (pause_e) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // Saturating speed code and the tick counter, which restarts whenever the speed changes.
  always_comb begin
    rate_d = rate_q;
    if (fast_e && !slow_e && rate_q != 2'd0)      rate_d = rate_q - 2'd1;
    else if (slow_e && !fast_e && rate_q != 2'd3) rate_d = rate_q + 2'd1;

    cnt_d = cnt_q;
    if (clr_e || rate_d != rate_q)  cnt_d = '0;
    else if (state_q == ST_RUN)     cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    else if (state_q == ST_IDLE)    cnt_d = '0;
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Speed, counter, key history and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q     <= 2'd2;
      cnt_q      <= '0;
      key_q      <= '0;
      step1      <= 1'b0;
      step2      <= 1'b0;
      game_clear <= 1'b0;
    end else begin
      rate_q     <= rate_d;
      cnt_q      <= cnt_d;
      key_q      <= keystroke[11:8];
      step1      <= step1_d;
      step2      <= step2_d;
      game_clear <= clr_e;
    end
  end

  dir_latch #(.RST_DIR(DIR1_RST)) u_dir1 (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_e),
    .keys   (keystroke[3:0]),
    .commit (step1_d),
    .dir    (dir1_q)
  );

  dir_latch #(.RST_DIR(DIR2_RST)) u_dir2 (
    .clk    (clk),
    .rst    (rst),
    .clear  (clr_e),
    .keys   (keystroke[7:4]),
    .commit (step2_d),
    .dir    (dir2_q)
  );

  assign dir1     = dir1_q;
  assign dir2     = dir2_q;
  assign clk_rate = rate_q;
  assign state    = state_q;

endmodule
